// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 widths, RAM
// byte-enable codes, and the memory-port FSM states.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  // The RAM takes a byte-enable code rather than a lane mask.
  localparam logic [3:0] BE_WORD   = 4'b0001;
  localparam logic [3:0] BE_HALF_L = 4'b0010;
  localparam logic [3:0] BE_HALF_H = 4'b0011;
  localparam logic [3:0] BE_BYTE0  = 4'b1000;
  localparam logic [3:0] BE_BYTE1  = 4'b1001;
  localparam logic [3:0] BE_BYTE2  = 4'b1010;
  localparam logic [3:0] BE_BYTE3  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RV,
    ST_RESP
  } state_e;

  function automatic logic [3:0] byte_be(input logic [1:0] off);
    logic [3:0] code;
    case (off)
      2'd0:    code = BE_BYTE0;
      2'd1:    code = BE_BYTE1;
      2'd2:    code = BE_BYTE2;
      default: code = BE_BYTE3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the RAM word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[off_i];
    // Halfword position is taken from off[1] alone; off[0] never moves it.
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one op at a time from execute to the data RAM,
// with load writeback. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_we_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic [4:0]        ex_rd_i,
  output logic              data_req_o,
  output logic [ADDR_W-1:0] data_add_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [XLEN-1:0]   data_wdata_o,
  output logic [4:0]        data_rd_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  input  logic [4:0]        data_rd_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  state_e          state_reg;
  logic [2:0]      funct3_reg;
  logic [1:0]      off_reg;
  logic [XLEN-1:0] load_aligned;

  logic            funct3_legal;
  logic            misalign_trap;
  logic [3:0]      be_code;
  logic [XLEN-1:0] wdata_rep;
  logic [1:0]      off_next;

  always_comb begin
    be_code      = BE_WORD;
    wdata_rep    = ex_wdata_i;
    funct3_legal = 1'b1;
    off_next     = ex_addr_i[1:0];
    case (ex_funct3_i)
      F3_B, F3_BU: begin
        be_code   = byte_be(ex_addr_i[1:0]);
        wdata_rep = {4{ex_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_code   = ex_addr_i[1] ? BE_HALF_H : BE_HALF_L;
        wdata_rep = {2{ex_wdata_i[15:0]}};
      end
      F3_W:    off_next = 2'd0;
      default: funct3_legal = 1'b0;
    endcase
    // Stores only come in B, H and W flavours.
    if (ex_we_i && (ex_funct3_i > 3'd2))
      funct3_legal = 1'b0;
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_trap =
      (((ex_funct3_i == F3_H) || (ex_funct3_i == F3_HU)) && ex_addr_i[0]) ||
      ((ex_funct3_i == F3_W) && (ex_addr_i[1:0] != 2'b00));
`else
  assign misalign_trap = 1'b0;
`endif

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i (funct3_reg),
    .off_i    (off_reg),
    .rdata_i  (data_rdata_i),
    .data_o   (load_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ex_ready_o   <= 1'b1;
      data_req_o   <= 1'b0;
      data_add_o   <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      data_rd_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      misalign_o   <= 1'b0;
      funct3_reg   <= '0;
      off_reg      <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Illegal ops are consumed by the handshake and silently dropped.
          if (ex_valid_i && ex_ready_o && funct3_legal) begin
            if (misalign_trap) begin
              misalign_o <= 1'b1;
            end else begin
              data_add_o   <= ex_addr_i;
              data_we_o    <= ex_we_i;
              data_be_o    <= be_code;
              data_wdata_o <= wdata_rep;
              data_rd_o    <= ex_rd_i;
              funct3_reg   <= ex_funct3_i;
              off_reg      <= off_next;
              data_req_o   <= 1'b1;
              ex_ready_o   <= 1'b0;
              state_reg    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            if (data_we_o) begin
              ex_ready_o <= 1'b1;
              state_reg  <= ST_IDLE;
            end else if (data_rvalid_i) begin
              wb_data_o  <= load_aligned;
              wb_rd_o    <= data_rd_o;
              wb_valid_o <= 1'b1;
              state_reg  <= ST_RESP;
            end else begin
              state_reg <= ST_WAIT_RV;
            end
          end
        end
        ST_WAIT_RV: begin
          if (data_rvalid_i) begin
            wb_data_o  <= load_aligned;
            wb_rd_o    <= data_rd_o;
            wb_valid_o <= 1'b1;
            state_reg  <= ST_RESP;
          end
        end
        default: begin
          ex_ready_o <= 1'b1;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The RAM must echo the tag of the load it is answering.
  rd_tag_match: assert property (@(posedge clk) disable iff (!rst_n)
    ((((state_reg == ST_REQ) && data_gnt_i) || (state_reg == ST_WAIT_RV)) &&
     data_rvalid_i && !data_we_o) |-> (data_rd_i == data_rd_o));
`endif

endmodule
